// File: rtl/pll_cmd_dispatch_if.sv
// Command handshake between the upstream SPI slave (master side) and the
// PLL command dispatcher (slave side): command word, bit count, dready level
// and the returned ack pulse.
interface pll_cmd_dispatch_if #(
   parameter int CMD_BIT_NUM = 41
);
   logic [CMD_BIT_NUM-1:0] data;
   logic [6:0]             data_num;
   logic                   dready;
   logic                   ack;

   modport master (output data, output data_num, output dready, input ack);
   modport slave  (input data, input data_num, input dready, output ack);
endinterface

// File: rtl/pll_cmd_dispatch.sv
// PLL command dispatcher.
// Takes a latched host command, checks it, and serialises the 32-bit PLL
// register word MSB-first over sclk/sdata, then strobes the selected chip's
// load enable and acks the command upstream.
// Optional feature macro: PLL_DISPATCH_BCAST_EN -- chip index 31 becomes a
// broadcast that strobes every le line at once.
module pll_cmd_dispatch #(
   parameter int         CMD_BIT_NUM = 41,
   parameter int         PLL_NUM     = 6,
   parameter logic [3:0] WR_OPCODE   = 4'b0001,
   parameter int         SCLK_DIV    = 4,
   parameter int         LE_WIDTH    = 4
) (
   input  logic               clk,
   input  logic               rst,
   pll_cmd_dispatch_if.slave  cmd,
   output logic               busy,
   output logic               cmd_err,
   output logic               pll_sclk,
   output logic               pll_sdata,
   output logic [PLL_NUM-1:0] pll_le
);

   localparam int DIV_W  = $clog2(SCLK_DIV + 1);
   localparam int LE_CW  = $clog2(LE_WIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
   localparam logic [LE_CW-1:0] LE_LAST   = LE_CW'(LE_WIDTH - 1);
   localparam logic [6:0]       CMD_NUM_W = 7'(CMD_BIT_NUM);
   localparam logic [4:0]       PLL_NUM_W = 5'(PLL_NUM);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CHECK    = 3'd1;
   localparam logic [2:0] ST_SHIFT_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT_HI = 3'd3;
   localparam logic [2:0] ST_SETTLE   = 3'd4;
   localparam logic [2:0] ST_LOAD     = 3'd5;
   localparam logic [2:0] ST_ACK      = 3'd6;
   localparam logic [2:0] ST_WAIT_CLR = 3'd7;

   // Registered state
   logic [2:0]             r_state;
   logic [CMD_BIT_NUM-1:0] r_cmd;
   logic [6:0]             r_num;
   logic [31:0]            r_shreg;
   logic [5:0]             r_bit_cnt;
   logic [DIV_W-1:0]       r_div_cnt;
   logic [LE_CW-1:0]       r_le_cnt;
   logic                   r_err;
   logic                   r_ack;
   logic                   r_cmd_err;
   logic                   r_sclk;
   logic                   r_sdata;
   logic [PLL_NUM-1:0]     r_le;

   // Next-state values
   logic [2:0]             w_state_nxt;
   logic [CMD_BIT_NUM-1:0] w_cmd_nxt;
   logic [6:0]             w_num_nxt;
   logic [31:0]            w_shreg_nxt;
   logic [5:0]             w_bit_cnt_nxt;
   logic [DIV_W-1:0]       w_div_cnt_nxt;
   logic [LE_CW-1:0]       w_le_cnt_nxt;
   logic                   w_err_nxt;

   // Decoded fields of the latched command
   logic [3:0]             w_opcode;
   logic [4:0]             w_idx;
   logic                   w_bcast;
   logic                   w_idx_bad;
   logic                   w_reject;
   logic                   w_div_done;
   logic                   w_le_done;
   logic [PLL_NUM-1:0]     w_le_mask;

   assign w_opcode   = r_cmd[CMD_BIT_NUM-1 -: 4];
   assign w_idx      = r_cmd[CMD_BIT_NUM-5 -: 5];
   assign w_div_done = (r_div_cnt == DIV_LAST);
   assign w_le_done  = (r_le_cnt == LE_LAST);

`ifdef PLL_DISPATCH_BCAST_EN
   assign w_bcast = (w_idx == 5'd31);
`else
   assign w_bcast = 1'b0;
`endif

   assign w_idx_bad = (w_idx >= PLL_NUM_W) && !w_bcast;
   assign w_reject  = (r_num != CMD_NUM_W) || (w_opcode != WR_OPCODE) || w_idx_bad;

   // Load-enable pattern: one-hot on the addressed chip, or all lines on broadcast
   always_comb begin
      w_le_mask = PLL_NUM'(1) << w_idx;
      if (w_bcast) begin
         w_le_mask = '1;
      end
   end

   // Next-state logic for the dispatch FSM, its counters and the shift register
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned,
      // which would otherwise infer a latch.
      w_state_nxt   = r_state;
      w_cmd_nxt     = r_cmd;
      w_num_nxt     = r_num;
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      w_div_cnt_nxt = r_div_cnt;
      w_le_cnt_nxt  = r_le_cnt;
      w_err_nxt     = r_err;

      case (r_state)
         ST_IDLE: begin
            if (cmd.dready) begin
               w_cmd_nxt   = cmd.data;
               w_num_nxt   = cmd.data_num;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (w_reject) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_ACK;
            end else begin
               w_shreg_nxt   = r_cmd[31:0];
               w_bit_cnt_nxt = '0;
               w_div_cnt_nxt = '0;
               w_state_nxt   = ST_SHIFT_LO;
            end
         end

         ST_SHIFT_LO: begin
            if (w_div_done) begin
               w_div_cnt_nxt = '0;
               w_state_nxt   = ST_SHIFT_HI;
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end

         ST_SHIFT_HI: begin
            if (w_div_done) begin
               w_div_cnt_nxt = '0;
               w_shreg_nxt   = {r_shreg[30:0], 1'b0};
               if (r_bit_cnt == 6'd31) begin
                  w_state_nxt = ST_SETTLE;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                  w_state_nxt   = ST_SHIFT_LO;
               end
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end

         ST_SETTLE: begin
            if (w_div_done) begin
               w_div_cnt_nxt = '0;
               w_le_cnt_nxt  = '0;
               w_state_nxt   = ST_LOAD;
            end else begin
               w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
         end

         ST_LOAD: begin
            if (w_le_done) begin
               w_le_cnt_nxt = '0;
               w_state_nxt  = ST_ACK;
            end else begin
               w_le_cnt_nxt = r_le_cnt + 1'b1;
            end
         end

         ST_ACK: begin
            w_state_nxt = ST_WAIT_CLR;
         end

         ST_WAIT_CLR: begin
            // Hold here until upstream drops dready so a frame is never taken twice
            if (!cmd.dready) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter and shift-register update; async reset clears everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cmd     <= '0;
         r_num     <= '0;
         // NOTE: the shift register and latched command are plain flops, not a
         // memory array, so they are cleared with the rest of the state.
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
         r_le_cnt  <= '0;
         r_err     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         r_state   <= w_state_nxt;
         r_cmd     <= w_cmd_nxt;
         r_num     <= w_num_nxt;
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_div_cnt <= w_div_cnt_nxt;
         r_le_cnt  <= w_le_cnt_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // Outputs registered from next state so PLL lines are glitch-free and
   // aligned with the state they belong to; reset drops them at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ack     <= 1'b0;
         r_cmd_err <= 1'b0;
         r_sclk    <= 1'b0;
         r_sdata   <= 1'b0;
         r_le      <= '0;
      end else begin
         r_ack     <= (w_state_nxt == ST_ACK);
         r_cmd_err <= (w_state_nxt == ST_ACK) && w_err_nxt;
         r_sclk    <= (w_state_nxt == ST_SHIFT_HI);
         r_sdata   <= ((w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI))
                      ? w_shreg_nxt[31] : 1'b0;
         r_le      <= (w_state_nxt == ST_LOAD) ? w_le_mask : '0;
      end
   end

   assign cmd.ack   = r_ack;
   assign cmd_err   = r_cmd_err;
   assign pll_sclk  = r_sclk;
   assign pll_sdata = r_sdata;
   assign pll_le    = r_le;
   assign busy      = (r_state != ST_IDLE);

endmodule
